// File: rtl/if_prefetch_if.sv
// ============================================================================
// Module   : if_prefetch_if
// Brief    : Fetch-stage bundle: instruction memory port, redirect inputs and
//            the valid/ready handshake toward ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_prefetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;
  logic               jr;
  logic [ADDR_W-1:0]  jr_target;
  logic               interrupt;
  logic               exception;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc_plus4,
    input  imem_rdata, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, interrupt, exception, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus4,
    output imem_rdata, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, interrupt, exception, id_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// Module   : if_prefetch
// Brief    : PC owner and prefetch queue feeding ID; resolves redirects.
//            Optional same-cycle bypass of an empty queue: IF_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_prefetch #(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic         clk,
  input  logic         rst,
  if_prefetch_if.master bus
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_FOUR  = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [INSTR_W-1:0] r_instr_q [DEPTH];
  logic [ADDR_W-1:0]  r_pc4_q   [DEPTH];

  logic               w_redirect;
  logic [ADDR_W-1:0]  w_target;
  logic               w_issue;
  logic               w_resp;
  logic [ADDR_W-1:0]  w_resp_pc4;
  logic               w_empty;
  logic               w_bypass;
  logic               w_valid;
  logic               w_pop;
  logic               w_pop_q;
  logic               w_push;
  logic [INSTR_W-1:0] w_head_instr;
  logic [ADDR_W-1:0]  w_head_pc4;

  // Fixed priority; interrupts are masked while fetching from kernel space.
  always_comb begin
    w_redirect = 1'b1;
    w_target   = EXC_VECTOR;
    if (bus.exception) begin
      w_target = EXC_VECTOR;
    end else if (bus.interrupt && !r_fetch_pc[ADDR_W-1]) begin
      w_target = IRQ_VECTOR;
    end else if (bus.jr) begin
      w_target = bus.jr_target;
    end else if (bus.jump) begin
      w_target = bus.jump_target;
    end else if (bus.branch_taken) begin
      w_target = bus.branch_target;
    end else begin
      w_redirect = 1'b0;
    end
  end

  // Credit counts queued plus in-flight words; a same-cycle pop is not credited.
  assign w_issue    = !rst && !w_redirect &&
                      ((r_count + c_CNT_W'(r_inflight)) < c_DEPTH);
  assign w_resp     = r_inflight && !w_redirect;
  assign w_resp_pc4 = r_inflight_pc + c_FOUR;
  assign w_empty    = (r_count == '0);

`ifdef IF_BYPASS_EN
  assign w_bypass = w_empty && w_resp;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid      = !w_redirect && (!w_empty || w_bypass);
  assign w_head_instr = w_bypass ? bus.imem_rdata : r_instr_q[r_rd_ptr];
  assign w_head_pc4   = w_bypass ? w_resp_pc4     : r_pc4_q[r_rd_ptr];
  assign w_pop        = w_valid && bus.id_ready;
  assign w_pop_q      = w_pop && !w_empty;
  assign w_push       = w_resp && !(w_bypass && bus.id_ready);

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.id_valid    = w_valid;
  assign bus.id_instr    = w_valid ? w_head_instr : '0;
  assign bus.id_pc_plus4 = w_valid ? w_head_pc4   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + c_FOUR;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop_q) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop_q);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= bus.imem_rdata;
      r_pc4_q[r_wr_ptr]   <= w_resp_pc4;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch.sv
// ============================================================================
// Module   : tb_if_prefetch
// Brief    : Directed self-checking bench for if_prefetch (ROM word = address).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  if_prefetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous ROM whose word equals its address.
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int          total = 0;
  int          bad   = 0;
  int          nreq;
  logic [31:0] exp_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboards any transfer in the current cycle, then advances one clock.
  task automatic cyc();
    #1;
    if (bus.id_valid && bus.id_ready) begin
      chk("deliver_instr", bus.id_instr, exp_instr);
      chk("deliver_pc4", bus.id_pc_plus4, exp_instr + 32'd4);
      exp_instr += 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.id_valid && n < 8) begin
      cyc();
      n++;
    end
    chk(tag, 32'(bus.id_valid), 32'd1);
  endtask

  initial begin
    rst               = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.jr            = 1'b0;
    bus.jr_target     = '0;
    bus.interrupt     = 1'b0;
    bus.exception     = 1'b0;
    bus.id_ready      = 1'b1;
    exp_instr         = 32'h8000_0000;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h8000_0000);
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_instr", bus.id_instr, 32'd0);
    chk("rst_pc4", bus.id_pc_plus4, 32'd0);

    // Sequential fetch after release.
    rst = 1'b0;
    #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h8000_0000);
    cyc();
    chk("t1_valid", 32'(bus.id_valid), 32'(BYP));
    chk("t1_addr", bus.imem_addr, 32'h8000_0004);
    cyc();
    chk("t2_valid", 32'(bus.id_valid), 32'd1);
    chk("t2_instr", bus.id_instr, BYP ? 32'h8000_0004 : 32'h8000_0000);
    repeat (4) begin
      chk("stream_no_gap", 32'(bus.id_valid), 32'd1);
      cyc();
    end

    // Back-pressure: outstanding work bounded by DEPTH.
    bus.id_ready = 1'b0;
    nreq = 0;
    repeat (10) begin
      #1;
      nreq += int'(bus.imem_req);
      cyc();
    end
    chk("stall_req_off", 32'(bus.imem_req), 32'd0);
    chk("stall_valid", 32'(bus.id_valid), 32'd1);
    chk("stall_nreq_le4", 32'(nreq <= 4), 32'd1);
    bus.id_ready = 1'b1;
    repeat (6) begin
      #1;
      chk("release_no_gap", 32'(bus.id_valid), 32'd1);
      cyc();
    end

    // Exception beats jump; in-flight word must not reach ID.
    bus.exception   = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 32'h0000_0200;
    #1;
    chk("exc_valid_forced0", 32'(bus.id_valid), 32'd0);
    chk("exc_req_off", 32'(bus.imem_req), 32'd0);
    cyc();
    bus.exception = 1'b0;
    bus.jump      = 1'b0;
    exp_instr     = 32'h8000_0008;
    #1;
    chk("exc_addr", bus.imem_addr, 32'h8000_0008);
    chk("exc_req", 32'(bus.imem_req), 32'd1);
    chk("exc_valid_flushed", 32'(bus.id_valid), 32'd0);
    wait_valid("exc_wait");
    chk("exc_first_instr", bus.id_instr, 32'h8000_0008);

    // Interrupt from user space is taken.
    bus.jump        = 1'b1;
    bus.jump_target = 32'h0000_0040;
    #1;
    cyc();
    bus.jump  = 1'b0;
    exp_instr = 32'h0000_0040;
    #1;
    chk("jmp_addr", bus.imem_addr, 32'h0000_0040);
    bus.interrupt = 1'b1;
    #1;
    chk("irq_taken_req", 32'(bus.imem_req), 32'd0);
    cyc();
    bus.interrupt = 1'b0;
    exp_instr     = 32'h8000_0004;
    #1;
    chk("irq_addr", bus.imem_addr, 32'h8000_0004);
    wait_valid("irq_wait");
    chk("irq_first_instr", bus.id_instr, 32'h8000_0004);

    // Interrupt from kernel space is ignored.
    for (int n = 0; n < 10 && bus.imem_addr != 32'h8000_0010; n++) cyc();
    chk("kern_addr", bus.imem_addr, 32'h8000_0010);
    bus.interrupt = 1'b1;
    #1;
    chk("irq_masked_req", 32'(bus.imem_req), 32'd1);
    cyc();
    bus.interrupt = 1'b0;
    #1;
    chk("irq_masked_next", bus.imem_addr, 32'h8000_0014);
    chk("pre_br_req", 32'(bus.imem_req), 32'd1);
    cyc();

    // Branch while a response is arriving: that response is dropped.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0100;
    #1;
    chk("br_valid_forced0", 32'(bus.id_valid), 32'd0);
    cyc();
    bus.branch_taken = 1'b0;
    exp_instr        = 32'h0000_0100;
    wait_valid("br_wait");
    chk("br_first_pc4", bus.id_pc_plus4, 32'h0000_0104);
    repeat (2) cyc();

    // Asynchronous mid-operation reset.
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.id_valid), 32'd0);
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the single-register fetch stage: owns the PC and fetches from a synchronous instruction memory.
- Buffers fetched instructions in a DEPTH-entry queue and hands them to ID over a valid/ready handshake.
- Resolves PC redirects (branch, jump, jr, interrupt, exception) with a fixed priority; redirects flush all wrong-path state.
- Sits between instruction memory and the ID stage of the 5-stage pipeline.

Parameters:
ADDR_W, 32, PC / address width
INSTR_W, 32, instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 32'h80000000, PC after reset
IRQ_VECTOR, 32'h80000004, interrupt entry
EXC_VECTOR, 32'h80000008, exception entry

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_W  fetch address
imem_rdata  in  INSTR_W  instruction, valid exactly 1 cycle after imem_req
branch_taken  in  1  branch redirect
branch_target  in  ADDR_W
jump  in  1  jump redirect
jump_target  in  ADDR_W
jr  in  1  jump-register redirect
jr_target  in  ADDR_W
interrupt  in  1  external interrupt request
exception  in  1  exception request
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head
id_instr  out  INSTR_W  head instruction (0 when id_valid=0)
id_pc_plus4  out  ADDR_W  head PC+4 (0 when id_valid=0)

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; queue empty; in-flight cleared.
  - Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc_plus4=0.
- Issue:
  - imem_req=1 when count+inflight < DEPTH and no redirect this cycle; imem_addr=fetch_pc.
  - On issue: fetch_pc += 4 (mod 2^ADDR_W, wraps silently); inflight set for the next cycle.
  - No credit is taken for a same-cycle pop.
- Response:
  - On the cycle after an issue, imem_rdata and its PC+4 are pushed into the queue, unless killed.
- Pop:
  - Transfer occurs when id_valid&&id_ready; head advances.
  - Push and pop in the same cycle leave count unchanged. Full-queue push cannot occur by construction.
- Redirect, priority exception > interrupt > jr > jump > branch_taken:
  - Target for each: EXC_VECTOR / IRQ_VECTOR / jr_target / jump_target / branch_target.
  - interrupt is ignored while fetch_pc[ADDR_W-1]=1 (kernel space); exception is never masked.
  - In the redirect cycle: id_valid forced 0 (no transfer), imem_req=0, queue flushed, any response arriving this cycle or the next is discarded.
  - fetch_pc <= target; the first request at target is issued the following cycle.
- Latency without bypass:
  - Request at cycle t, push at t+1, id_valid at t+2.
  - Steady-state throughput is 1 instruction/cycle with id_ready=1.
- Mid-operation reset: all state is discarded immediately; no partial transfer.
- Counter widths: count is clog2(DEPTH)+1 bits; read/write pointers are clog2(DEPTH) bits and wrap.

Optional Feature:
IF_BYPASS_EN
- Defined: when the queue is empty and a non-killed response arrives, it is presented on id_* in the same cycle (id_valid at t+1).
  - If id_ready=1, it is consumed and not written to the queue.
  - If id_ready=0, it is pushed normally.
- Undefined: every response goes through the queue; id_valid is never asserted before t+2.

Test Plan:
- Reset then release, id_ready=1, ROM word=address → imem_addr 0x80000000,04,08…; id_instr=0x80000000 with id_pc_plus4=0x80000004 two cycles after first req, then one per cycle, no gaps.
- id_ready=0 for 10 cycles (DEPTH=4) → at most 4 requests issued then imem_req=0; on release, 4 sequential instructions delivered with no loss or duplication, fetching resumes.
- exception=1 and jump=1 (jump_target 0x00000200) same cycle → next imem_addr=0x80000008; id_valid=0 until the EXC_VECTOR word arrives; the in-flight word is never delivered.
- interrupt=1 with fetch_pc=0x00000040 → redirect to 0x80000004; interrupt=1 with fetch_pc=0x80000010 → ignored, sequential fetch continues.
- branch_taken=1 (target 0x00000100) in the cycle a response arrives → that response dropped; first delivered id_pc_plus4=0x00000104.
- With IF_BYPASS_EN, empty queue, id_ready=1 → id_valid one cycle after imem_req; without the macro, two cycles.
